alu_pipe_hs: RTL
================

// Module: alu_pipe_hs
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshake on input and output; next generation of the
//  combinational datapath ALU, used by the execute stage when stall-tolerant issue is required.
//  Single-issue: one operation in flight. Simple ops complete in one cycle; optional iterative MUL.
//  Flags (N, Z, V, C) are registered alongside the result and held until consumed.
// PARAMETERS
//  WIDTH      64   operand/result width in bits (>= 8)
//  CNT_W      $clog2(WIDTH)+1   multiply iteration counter width (derived, not overridden)
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  in_valid    in   1       operation presented on A/B/cntrl
//  in_ready    out  1       block accepts operation this cycle
//  A           in   WIDTH   operand A
//  B           in   WIDTH   operand B
//  cntrl       in   3       opcode (see BEHAVIOUR)
//  out_valid   out  1       result/flags valid
//  out_ready   in   1       consumer takes result this cycle
//  result      out  WIDTH   registered result
//  negative    out  1       result[WIDTH-1]
//  zero        out  1       result == 0
//  overflow    out  1       signed overflow (ADD/SUB only, else 0)
//  carry_out   out  1       carry out (ADD/SUB only, else 0)
// BEHAVIOUR
//  Opcodes: 000 PASS_B, 001 reserved, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MUL.
//  Reserved opcode (and MUL when compiled out): result 0, zero=1, other flags 0, one-cycle latency.
//  SUB = A + ~B + 1; carry_out = carry of that sum (1 = no borrow). V = (sA==sB')&&(sR!=sA), sB'=sign of B or ~B.
//  Arithmetic modulo 2^WIDTH; carry is bit WIDTH of the (WIDTH+1)-bit sum.
//  Accept: transfer when in_valid && in_ready at rising edge. Output: transfer when out_valid && out_ready.
//  in_ready = (state==IDLE) && (!out_valid || out_ready)  -- combinational; allows back-to-back issue.
//  FSM: IDLE -> (accept simple op) IDLE with out_valid=1 next cycle;
//       IDLE -> (accept MUL) MUL; MUL counts WIDTH cycles; MUL -> IDLE with out_valid=1 on final edge.
//  Latency: simple op accepted at edge k -> out_valid high after edge k. MUL accepted at edge k -> out_valid after edge k+WIDTH.
//  Throughput: 1 simple op/cycle while out_ready=1. in_ready=0 throughout MUL.
//  Hold: while out_valid && !out_ready, result and all flags stable; in_ready=0.
//  Simultaneous out transfer + new accept: result/flags replaced, out_valid stays 1.
//  out transfer with no accept: out_valid -> 0; result/flags hold last value (don't care).
//  A/B/cntrl sampled only on accept; changes during MUL have no effect.
//  Reset (async, any time incl. mid-MUL): state=IDLE, counter=0, out_valid=0, result=0, negative=0,
//  zero=0, overflow=0, carry_out=0; in-flight op discarded. in_ready=1 once reset_n high.
// CONFIGURATION
//  ALU_MUL_EN defined: opcode 111 = unsigned shift-add multiply, result = low WIDTH bits of A*B,
//    N/Z from result, V=C=0, WIDTH-cycle iteration in MUL state.
//  ALU_MUL_EN undefined: no MUL state/counter/multiplicand regs; 111 treated as reserved (result 0, 1 cycle).
// TESTING  (WIDTH=64)
//  ADD A=64'h7FFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> next cycle result=64'h8000_0000_0000_0000, N=1 V=1 C=0 Z=0.
//  SUB A=5, B=5 -> result=0, Z=1, C=1, V=0; SUB A=0, B=1 -> result=all ones, N=1, C=0.
//  Back-pressure: AND then OR issued, out_ready=0 two cycles -> in_ready=0, AND result held; release -> OR next cycle.
//  Streaming XOR/PASS_B every cycle, out_ready=1 -> one result per cycle, in_ready never drops.
//  ALU_MUL_EN: MUL A=12345, B=678 -> in_ready=0 for 64 cycles, out_valid after edge k+64, result=8369910.
//  reset_n pulsed low mid-MUL (cycle 20) -> all outputs 0 immediately, in_ready=1 after release, no stale out_valid.

Source files
------------

// File: rtl/alu_pipe_hs.sv
// Registered ALU with valid/ready handshakes on input and output; one operation in flight.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module alu_pipe_hs #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam logic [2:0] OpPass = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpOr   = 3'b101;
  localparam logic [2:0] OpXor  = 3'b110;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             negative_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_q;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_c;
  logic             idle;
  logic             accept;
  logic             out_xfer;

`ifdef ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_next;
  logic             mul_last;
  logic             is_mul;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
  assign is_mul   = (cntrl == 3'b111);
  assign idle     = (state_q == StIdle);
`else
  assign idle     = 1'b1;
`endif

  assign in_ready = idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // SUB is A + ~B + 1, so carry_out is the inverted borrow.
  always_comb begin
    b_eff   = (cntrl == OpSub) ? ~B : B;
    sum     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (cntrl == OpSub)};
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (cntrl)
      OpPass: alu_res = B;
      OpAdd, OpSub: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OpAnd:  alu_res = A & B;
      OpOr:   alu_res = A | B;
      OpXor:  alu_res = A ^ B;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (state_q == StMul) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (mul_last) begin
          state_q     <= StIdle;
          cnt_q       <= '0;
          result_q    <= acc_next;
          negative_q  <= acc_next[WIDTH-1];
          zero_q      <= (acc_next == '0);
          overflow_q  <= 1'b0;
          carry_q     <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end else if (accept && is_mul) begin
        state_q     <= StMul;
        cnt_q       <= '0;
        acc_q       <= '0;
        mcand_q     <= A;
        mplier_q    <= B;
        out_valid_q <= 1'b0;
      end else
`endif
      if (accept) begin
        result_q    <= alu_res;
        negative_q  <= alu_res[WIDTH-1];
        zero_q      <= (alu_res == '0);
        overflow_q  <= alu_v;
        carry_q     <= alu_c;
        out_valid_q <= 1'b1;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_q;

endmodule
